// File: rtl/cga_intr_level_pend_bank_if.sv
// Microcode write bus and ident handshake for the interrupt level pending/enable bank.
// The master (CPU/microcode side) drives writes and IDENT; the slave (bank) returns the ACK strobe.
interface cga_intr_level_pend_bank_if #(
  parameter int NLEV = 16
);
  localparam int LW = $clog2(NLEV);

  // Handshake: IDENT is raised and held high until ACK_VLD has been seen for one cycle.
  // ACK_VLD is a single-cycle strobe. ACK_LVL and ACK_NONE are valid with it and hold until
  // the next request.
  logic            PID_WR;
  logic            PIE_WR;
  logic [NLEV-1:0] WDATA;
  logic            IDENT;
  logic            ACK_VLD;
  logic [LW-1:0]   ACK_LVL;
  logic            ACK_NONE;

  modport master (
    output PID_WR, PIE_WR, WDATA, IDENT,
    input  ACK_VLD, ACK_LVL, ACK_NONE
  );

  modport slave (
    input  PID_WR, PIE_WR, WDATA, IDENT,
    output ACK_VLD, ACK_LVL, ACK_NONE
  );
endinterface

// File: rtl/cga_intr_level_pend_bank.sv
// Interrupt level pending (PID) / enable (PIE) bank with a registered priority encoder and ident handshake.
// Define CGA_INTR_HWSET_SYNC_EN to pass HWSET through a 2-flop synchroniser before use.
module cga_intr_level_pend_bank #(
  parameter int                NLEV    = 16,
  parameter logic [NLEV-1:0]   CLRMASK = NLEV'(16'h3C00),
  parameter bit                PIE_RST = 1'b0,
  localparam int               LW      = $clog2(NLEV)
) (
  input  logic                         MCLK,
  input  logic                         MRN,
  input  logic [NLEV-1:0]              HWSET,
  input  logic [LW-1:0]                PIL,
  output logic [NLEV-1:0]              PID,
  output logic [NLEV-1:0]              PIE,
  output logic                         IRQ,
  output logic [LW-1:0]                IRQ_LVL,
  output logic [1:0]                   dbgState,
  cga_intr_level_pend_bank_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    WAITLO = 2'd2
  } state_t;

  state_t          state;
  logic            ackVld;
  logic [LW-1:0]   ackLvl;
  logic            ackNone;
  logic [NLEV-1:0] hs;
  logic [NLEV-1:0] clr;
  logic [NLEV-1:0] act;
  logic [NLEV-1:0] pidNext;
  logic [LW-1:0]   top;

`ifdef CGA_INTR_HWSET_SYNC_EN
  logic [NLEV-1:0] hsMeta;
  logic [NLEV-1:0] hsSync;

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      hsMeta <= '0;
      hsSync <= '0;
    end else begin
      hsMeta <= HWSET;
      hsSync <= hsMeta;
    end
  end

  assign hs = hsSync;
`else
  assign hs = HWSET;
`endif

  // Only the level reported in the response cycle may clear, and only if it is auto-clearing.
  always_comb begin
    clr = '0;
    if (state == RESP && !ackNone && CLRMASK[ackLvl])
      clr[ackLvl] = 1'b1;
  end

  // Hardware set wins over the ident clear, which wins over a microcode write.
  assign pidNext = ((bus.PID_WR ? bus.WDATA : PID) & ~clr) | hs;
  assign act     = PID & PIE;

  always_comb begin
    top = '0;
    for (int i = 0; i < NLEV; i++)
      if (act[i]) top = LW'(i);
  end

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      PID     <= '0;
      PIE     <= {NLEV{PIE_RST}};
      IRQ     <= 1'b0;
      IRQ_LVL <= '0;
    end else begin
      PID     <= pidNext;
      if (bus.PIE_WR) PIE <= bus.WDATA;
      IRQ_LVL <= top;
      IRQ     <= (act != '0) && (top > PIL);
    end
  end

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      state   <= IDLE;
      ackVld  <= 1'b0;
      ackLvl  <= '0;
      ackNone <= 1'b0;
    end else begin
      ackVld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.IDENT) begin
            ackLvl  <= top;
            ackNone <= (act == '0);
            ackVld  <= 1'b1;
            state   <= RESP;
          end
        end
        RESP:    state <= WAITLO;
        WAITLO:  if (!bus.IDENT) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK_VLD  = ackVld;
  assign bus.ACK_LVL  = ackLvl;
  assign bus.ACK_NONE = ackNone;
  assign dbgState     = state;

endmodule

// File: tb/tb_cga_intr_level_pend_bank.sv
// Directed bench for cga_intr_level_pend_bank: reset, IRQ latency/PIL, ident clear, collisions, mid-handshake reset.
module tb_cga_intr_level_pend_bank;
  localparam int NLEV = 16;
  localparam int LW   = 4;

  logic            MCLK;
  logic            MRN;
  logic [NLEV-1:0] HWSET;
  logic [LW-1:0]   PIL;
  logic [NLEV-1:0] PID;
  logic [NLEV-1:0] PIE;
  logic            IRQ;
  logic [LW-1:0]   IRQ_LVL;
  logic [1:0]      dbgState;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q[$];

  cga_intr_level_pend_bank_if #(.NLEV(NLEV)) bus ();

  cga_intr_level_pend_bank dut (
    .MCLK     (MCLK),
    .MRN      (MRN),
    .HWSET    (HWSET),
    .PIL      (PIL),
    .PID      (PID),
    .PIE      (PIE),
    .IRQ      (IRQ),
    .IRQ_LVL  (IRQ_LVL),
    .dbgState (dbgState),
    .bus      (bus)
  );

  // clock / reset
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are then sampled 1ns after it
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic write_pid(input logic [NLEV-1:0] d);
    bus.PID_WR = 1'b1;
    bus.WDATA  = d;
    tick();
    bus.PID_WR = 1'b0;
  endtask

  task automatic write_pie(input logic [NLEV-1:0] d);
    bus.PIE_WR = 1'b1;
    bus.WDATA  = d;
    tick();
    bus.PIE_WR = 1'b0;
  endtask

  // hold IDENT for n edges, count strobes, compare against the scoreboard, then release
  task automatic ident_req(input string tag, input int n, input logic exp_none);
    int acks;
    logic [LW-1:0] exp_lvl;
    acks = 0;
    bus.IDENT = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      if (bus.ACK_VLD) begin
        acks++;
        exp_lvl = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_lvl"}, 32'(bus.ACK_LVL), 32'(exp_lvl));
        chk({tag, "_none"}, 32'(bus.ACK_NONE), 32'(exp_none));
      end
    end
    chk({tag, "_acks"}, 32'(acks), 32'd1);
    bus.IDENT = 1'b0;
    tick();
  endtask

  initial begin
    MRN        = 1'b0;
    HWSET      = '1;
    PIL        = '0;
    bus.PID_WR = 1'b0;
    bus.PIE_WR = 1'b0;
    bus.WDATA  = '0;
    bus.IDENT  = 1'b0;

    // 1: reset holds everything at zero even with HWSET asserted
    repeat (3) tick();
    chk("rst_pid",     32'(PID),          32'h0);
    chk("rst_pie",     32'(PIE),          32'h0);
    chk("rst_irq",     32'(IRQ),          32'h0);
    chk("rst_irqlvl",  32'(IRQ_LVL),      32'h0);
    chk("rst_ackvld",  32'(bus.ACK_VLD),  32'h0);
    chk("rst_acklvl",  32'(bus.ACK_LVL),  32'h0);
    chk("rst_acknone", 32'(bus.ACK_NONE), 32'h0);
    chk("rst_state",   32'(dbgState),     32'h0);
    MRN = 1'b1;
    tick();
    chk("rel_pid", 32'(PID), 32'hFFFF);
    HWSET = '0;
    write_pid(16'h0000);
    chk("clr_pid", 32'(PID), 32'h0);

    // 2: pulse on level 12 with PIL 9; IRQ one edge after PID
    write_pie(16'hFFFF);
    chk("pie_wr", 32'(PIE), 32'hFFFF);
    PIL = 4'd9;
    HWSET[12] = 1'b1;
    tick();
    HWSET = '0;
    chk("hw12_pid", 32'(PID), 32'h1000);
    chk("hw12_irq_early", 32'(IRQ), 32'h0);
    tick();
    chk("hw12_irq", 32'(IRQ), 32'h1);
    chk("hw12_irqlvl", 32'(IRQ_LVL), 32'd12);
    PIL = 4'd12;
    tick();
    chk("pil12_irq", 32'(IRQ), 32'h0);
    PIL = 4'd11;
    tick();
    chk("pil11_irq", 32'(IRQ), 32'h1);
    write_pie(16'h0000);
    tick();
    chk("pie0_irq", 32'(IRQ), 32'h0);
    chk("pie0_pid", 32'(PID), 32'h1000);
    write_pie(16'hFFFF);
    PIL = 4'd0;

    // 3: two idents drain levels 12 then 10
    write_pid(16'h1400);
    exp_q.push_back(4'd12);
    ident_req("id12", 5, 1'b0);
    chk("id12_pid", 32'(PID), 32'h0400);
    exp_q.push_back(4'd10);
    ident_req("id10", 3, 1'b0);
    chk("id10_pid", 32'(PID), 32'h0000);

    // 4: nothing pending, then a level without auto-clear
    exp_q.push_back(4'd0);
    ident_req("idnone", 3, 1'b1);
    chk("idnone_pid", 32'(PID), 32'h0000);
    write_pid(16'h0002);
    exp_q.push_back(4'd1);
    ident_req("id1", 3, 1'b0);
    chk("id1_pid", 32'(PID), 32'h0002);
    write_pid(16'h0000);

    // 5a: write during RESP still loses the cleared bit
    write_pid(16'h0800);
    bus.IDENT = 1'b1;
    tick();
    chk("col_a_ackvld", 32'(bus.ACK_VLD), 32'h1);
    chk("col_a_acklvl", 32'(bus.ACK_LVL), 32'd11);
    bus.PID_WR = 1'b1;
    bus.WDATA  = 16'h0800;
    tick();
    bus.PID_WR = 1'b0;
    bus.IDENT  = 1'b0;
    chk("col_a_pid", 32'(PID), 32'h0000);
    tick();
    chk("col_a_state", 32'(dbgState), 32'h0);

    // 5b: HWSET in the same RESP cycle wins over the clear
    write_pid(16'h0800);
    bus.IDENT = 1'b1;
    tick();
    HWSET[11]  = 1'b1;
    bus.PID_WR = 1'b1;
    bus.WDATA  = 16'h0800;
    tick();
    HWSET      = '0;
    bus.PID_WR = 1'b0;
    bus.IDENT  = 1'b0;
    chk("col_b_pid", 32'(PID), 32'h0800);
    tick();
    write_pid(16'h0000);

    // 6: reset while waiting for IDENT low
    write_pid(16'h1400);
    bus.IDENT = 1'b1;
    tick();
    tick();
    chk("mid_state_wait", 32'(dbgState), 32'h2);
    MRN = 1'b0;
    #2;
    chk("mid_ackvld",  32'(bus.ACK_VLD),  32'h0);
    chk("mid_acklvl",  32'(bus.ACK_LVL),  32'h0);
    chk("mid_acknone", 32'(bus.ACK_NONE), 32'h0);
    chk("mid_state",   32'(dbgState),     32'h0);
    bus.IDENT = 1'b0;
    MRN = 1'b1;
    tick();
    write_pie(16'hFFFF);
    write_pid(16'h2000);
    exp_q.push_back(4'd13);
    ident_req("post_rst", 3, 1'b0);
    chk("post_rst_pid", 32'(PID), 32'h0000);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
